riscv_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I-subset core. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath's `riscv_control_t` bundle, instruction-register load, PC update and memory handshakes. It sits between the instruction register/ALU datapath and the instruction/data memory ports, replacing per-cycle combinational decode with a registered, state-qualified control word.

---
 rtl/riscv_mc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I-subset core.
// Optional feature macro: RISCV_ILLEGAL_TRAP_EN (unknown opcode parks the core in TRAP until reset).

package riscv_pkg;

   typedef enum logic [3:0] {
      alu_add  = 4'h0,
      alu_sub  = 4'h1,
      alu_sll  = 4'h2,
      alu_slt  = 4'h3,
      alu_sltu = 4'h4,
      alu_xor  = 4'h5,
      alu_srl  = 4'h6,
      alu_sra  = 4'h7,
      alu_or   = 4'h8,
      alu_and  = 4'h9,
      alu_ndef = 4'hF
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_write;
      logic    branch;
      logic    branch_neq;
      logic    jump;
   } riscv_control_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_REG   = 7'b0110011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JUMP  = 7'b1101111;

   localparam logic [2:0] F3_BNEQ = 3'b001;

   // funct3 to ALU operation; alt selects the sub/sra variant of add/srl
   function automatic alu_op_t alu_map(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? alu_sub : alu_add;
         3'b001:  return alu_sll;
         3'b010:  return alu_slt;
         3'b011:  return alu_sltu;
         3'b100:  return alu_xor;
         3'b101:  return alt ? alu_sra : alu_srl;
         3'b110:  return alu_or;
         default: return alu_and;
      endcase
   endfunction

endpackage

module riscv_mc_ctrl
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr,
   input  logic                 alu_zero,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 ir_write,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   output riscv_control_t       ctrl,
   output logic                 pc_write,
   output logic                 pc_sel,
   output logic [CNT_W-1:0]     instret,
   output logic                 illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
`ifdef RISCV_ILLEGAL_TRAP_EN
      WB     = 3'd4,
      TRAP   = 3'd5
`else
      WB     = 3'd4
`endif
   } state_t;

   localparam riscv_control_t CTRL_RST = '{alu_op: alu_ndef, default: 1'b0};

   state_t         state_q, state_d;
   riscv_control_t ctrl_q, dec;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // opcode/funct decode into a fresh control word; unknown opcodes stay alu_ndef with no flags
   always_comb begin
      dec        = CTRL_RST;
      case (opcode)
         OPC_REG: begin
            dec.alu_op    = alu_map(funct3, instr[30]);
            dec.reg_write = 1'b1;
         end
         OPC_IMM: begin
            dec.alu_op    = alu_map(funct3, instr[30] && funct3 == 3'b101);
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu_op     = alu_add;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
         end
         OPC_STORE: begin
            dec.alu_op    = alu_add;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OPC_BR: begin
            dec.alu_op     = alu_sub;
            dec.branch     = 1'b1;
            dec.branch_neq = funct3 == F3_BNEQ;
         end
         OPC_JUMP: begin
            dec.alu_op    = alu_add;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: dec = CTRL_RST;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // next-state sequencing; memory states wait for their ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = imem_ack ? DECODE : FETCH;
`ifdef RISCV_ILLEGAL_TRAP_EN
         DECODE:  state_d = (dec.alu_op == alu_ndef) ? TRAP : EXEC;
         TRAP:    state_d = TRAP;
`else
         DECODE:  state_d = EXEC;
`endif
         EXEC:    state_d = (ctrl_q.mem_read || ctrl_q.mem_write) ? MEM : ctrl_q.reg_write ? WB : FETCH;
         MEM:     state_d = !dmem_ack ? MEM : ctrl_q.mem_read ? WB : FETCH;
         WB:      state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // state-qualified outputs; requests are pure Moore, completion pulses follow the acks
   always_comb begin
      imem_req       = state_q == FETCH;
      ir_write       = state_q == FETCH && imem_ack;
      dmem_req       = state_q == MEM;
      dmem_we        = state_q == MEM && ctrl_q.mem_write;
      pc_write       = (state_q == EXEC && (ctrl_q.branch || ctrl_q.alu_op == alu_ndef)) ||
                       (state_q == MEM && dmem_ack && ctrl_q.mem_write) ||
                       state_q == WB;
      pc_sel         = (state_q == EXEC && ctrl_q.branch && (alu_zero ^ ctrl_q.branch_neq)) ||
                       (state_q == WB && ctrl_q.jump);
      ctrl           = ctrl_q;
      ctrl.reg_write = ctrl_q.reg_write && state_q == WB;
   end

   // control word captured in DECODE, retire counter stepped by every PC update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_RST;
         instret <= '0;
      end else begin
         if (state_q == DECODE) ctrl_q <= dec;
         instret <= instret + CNT_W'(pc_write);
      end
   end

`ifdef RISCV_ILLEGAL_TRAP_EN
   // sticky flag raised on the way into TRAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     illegal <= 1'b0;
      else if (state_q == DECODE && state_d == TRAP) illegal <= 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: directed self-checking bench for the multi-cycle control sequencer.
module tb_riscv_mc_ctrl;
   import riscv_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [31:0]    instr = '0;
   logic           alu_zero = 1'b0;
   logic           imem_ack = 1'b0;
   logic           dmem_ack = 1'b0;
   logic           imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, illegal;
   riscv_control_t ctrl;
   logic [31:0]    instret;

   int checks = 0;
   int errors = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   riscv_mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_write(ir_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ctrl(ctrl), .pc_write(pc_write), .pc_sel(pc_sel),
      .instret(instret), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FETCH (optionally stalled) and DECODE; returns one step after the edge into EXEC
   task automatic fetch(input logic [31:0] ins, input int wait_n);
      instr = ins;
      repeat (wait_n) begin
         #1;
         chk("fetch_wait_req", imem_req, 1);
         chk("fetch_wait_ir", ir_write, 0);
         tick();
      end
      imem_ack = 1'b1;
      #1;
      chk("fetch_ir", ir_write, 1);
      chk("fetch_pcw", pc_write, 0);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("dec_ir", ir_write, 0);
      chk("dec_req", imem_req, 0);
      tick();
   endtask

   // register-writing ALU instruction: EXEC then WB then back to FETCH
   task automatic run_alu(input string tag, input logic [31:0] ins, input logic [3:0] op,
                          input logic src, input int wait_n);
      fetch(ins, wait_n);
      #1;
      chk({tag, "_op"}, ctrl.alu_op, op);
      chk({tag, "_src"}, ctrl.alu_src, src);
      chk({tag, "_rw_exec"}, ctrl.reg_write, 0);
      chk({tag, "_pcw_exec"}, pc_write, 0);
      tick();
      #1;
      chk({tag, "_rw_wb"}, ctrl.reg_write, 1);
      chk({tag, "_pcw_wb"}, pc_write, 1);
      chk({tag, "_pcsel_wb"}, pc_sel, 0);
      tick();
      exp_ret++;
      #1;
      chk({tag, "_ret"}, instret, exp_ret);
      chk({tag, "_next_req"}, imem_req, 1);
      chk({tag, "_rw_fetch"}, ctrl.reg_write, 0);
   endtask

   // branch resolved in EXEC with the given zero flag
   task automatic run_br(input string tag, input logic [31:0] ins, input logic zero, input logic sel);
      fetch(ins, 0);
      alu_zero = zero;
      #1;
      chk({tag, "_op"}, ctrl.alu_op, alu_sub);
      chk({tag, "_branch"}, ctrl.branch, 1);
      chk({tag, "_pcw"}, pc_write, 1);
      chk({tag, "_pcsel"}, pc_sel, sel);
      chk({tag, "_irw"}, ir_write, 0);
      tick();
      alu_zero = 1'b0;
      exp_ret++;
      #1;
      chk({tag, "_ret"}, instret, exp_ret);
      chk({tag, "_next_req"}, imem_req, 1);
   endtask

   initial begin
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
      chk("rst_imem_req", imem_req, 1);
      chk("rst_ctrl", ctrl, 32'h0000_0F00);
      chk("rst_instret", instret, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_pcw", pc_write, 0);
      chk("rst_irw", ir_write, 0);
      chk("rst_dreq", dmem_req, 0);

      run_alu("add", 32'h002081B3, alu_add, 1'b0, 0);
      run_alu("sub", 32'h402081B3, alu_sub, 1'b0, 1);
      run_alu("sra", 32'h4020D1B3, alu_sra, 1'b0, 0);
      run_alu("addi", 32'h40008093, alu_add, 1'b1, 2);
      run_alu("srai", 32'h4010D093, alu_sra, 1'b1, 0);

      fetch(32'h0000A283, 0);
      #1;
      chk("lw_op", ctrl.alu_op, alu_add);
      chk("lw_mrd", ctrl.mem_read, 1);
      chk("lw_pcw_exec", pc_write, 0);
      tick();
      repeat (3) begin
         #1;
         chk("lw_dreq_wait", dmem_req, 1);
         chk("lw_dwe_wait", dmem_we, 0);
         chk("lw_pcw_wait", pc_write, 0);
         tick();
      end
      dmem_ack = 1'b1;
      #1;
      chk("lw_dreq_ack", dmem_req, 1);
      chk("lw_pcw_ack", pc_write, 0);
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("lw_dreq_wb", dmem_req, 0);
      chk("lw_pcw_wb", pc_write, 1);
      chk("lw_m2r_wb", ctrl.mem_to_reg, 1);
      chk("lw_rw_wb", ctrl.reg_write, 1);
      tick();
      exp_ret++;
      #1;
      chk("lw_ret", instret, exp_ret);

      fetch(32'h0020A023, 0);
      #1;
      chk("sw_mwr", ctrl.mem_write, 1);
      chk("sw_src", ctrl.alu_src, 1);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("sw_dwe", dmem_we, 1);
      chk("sw_pcw", pc_write, 1);
      chk("sw_pcsel", pc_sel, 0);
      chk("sw_rw", ctrl.reg_write, 0);
      tick();
      dmem_ack = 1'b0;
      exp_ret++;
      #1;
      chk("sw_ret", instret, exp_ret);
      chk("sw_next_req", imem_req, 1);
      chk("sw_dreq_off", dmem_req, 0);

      run_br("beq_t", 32'h00208463, 1'b1, 1'b1);
      run_br("beq_nt", 32'h00208463, 1'b0, 1'b0);
      run_br("bne_t", 32'h00209463, 1'b0, 1'b1);
      run_br("bne_nt", 32'h00209463, 1'b1, 1'b0);

      fetch(32'h008000EF, 0);
      #1;
      chk("jal_jump", ctrl.jump, 1);
      chk("jal_op", ctrl.alu_op, alu_add);
      chk("jal_pcw_exec", pc_write, 0);
      tick();
      #1;
      chk("jal_pcw", pc_write, 1);
      chk("jal_pcsel", pc_sel, 1);
      chk("jal_rw", ctrl.reg_write, 1);
      tick();
      exp_ret++;
      #1;
      chk("jal_ret", instret, exp_ret);

      fetch(32'h0000A283, 0);
      tick();
      #1;
      chk("rstm_dreq_before", dmem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("rstm_dreq", dmem_req, 0);
      chk("rstm_imem_req", imem_req, 1);
      chk("rstm_instret", instret, 0);
      chk("rstm_ctrl", ctrl, 32'h0000_0F00);
      tick();
      rst_n = 1'b1;
      exp_ret = 0;
      #1;
      chk("rstm_release_req", imem_req, 1);

      fetch(32'h0000007F, 0);
`ifdef RISCV_ILLEGAL_TRAP_EN
      #1;
      chk("trap_illegal", illegal, 1);
      repeat (20) begin
         chk("trap_imem_req", imem_req, 0);
         chk("trap_pcw", pc_write, 0);
         tick();
      end
      chk("trap_instret", instret, exp_ret);
      chk("trap_illegal_sticky", illegal, 1);
`else
      #1;
      chk("nop_ctrl", ctrl, 32'h0000_0F00);
      chk("nop_pcw", pc_write, 1);
      chk("nop_pcsel", pc_sel, 0);
      tick();
      exp_ret++;
      #1;
      chk("nop_ret", instret, exp_ret);
      chk("nop_illegal", illegal, 0);
      chk("nop_next_req", imem_req, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
